dfr_phase_sequencer: RTL and testbench
======================================

DFR_PHASE_SEQUENCER -- requirements
Module: dfr_phase_sequencer

Interface
REQ-001 Parameter CNT_W, default 32, width of the sample/step counters and config inputs.
REQ-002 S_AXI_ACLK  input  1  block clock, rising edge.
REQ-003 Local_Reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle run request (ctrl bit 0).
REQ-005 num_init_samples / num_train_samples / num_test_samples  input  CNT_W  sample count per phase.
REQ-006 num_steps_per_sample  input  CNT_W  reservoir steps per sample.
REQ-007 step_req  output  1  request one datapath step.
REQ-008 step_ack  input  1  datapath accepted/completed the requested step.
REQ-009 phase  output  2  0=idle, 1=init, 2=train, 3=test.
REQ-010 sample_idx / step_idx  output  CNT_W  current sample and step within the phase, zero-based.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  single-cycle pulse at run completion.

Function
REQ-013 The FSM states SHALL be IDLE, INIT, TRAIN, TEST, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-014 When start=1 in IDLE, the block SHALL latch all four config inputs and enter the first phase with a nonzero sample count on the next edge.
REQ-015 A phase with zero samples SHALL be skipped with no cycle spent in it; if all are zero, or num_steps_per_sample=0, the FSM SHALL go IDLE->DONE.
REQ-016 step_req SHALL be high in INIT/TRAIN/TEST and stay high until sampled with step_ack=1.
REQ-017 Each cycle with step_req=1 and step_ack=1 SHALL increment step_idx; at step_idx=steps-1, step_idx wraps to 0 and sample_idx increments.
REQ-018 At sample_idx=samples-1 and step_idx=steps-1 with the handshake, the FSM SHALL advance to the next nonempty phase, or DONE, with both counters cleared.
REQ-019 step_req SHALL stay high across back-to-back steps and phase transitions, with no bubble, so one step completes per cycle when step_ack is held high.
REQ-020 start SHALL be ignored while busy=1; config input changes during a run SHALL have no effect.
REQ-021 step_ack with step_req=0 SHALL be ignored.
REQ-022 Counter comparisons SHALL use latched CNT_W-bit values; a configured count of 2^CNT_W-1 SHALL complete without overflow.
REQ-023 phase SHALL equal the phase encoding of the current state; it SHALL read 0 in IDLE and DONE.

Reset
REQ-024 Local_Reset SHALL asynchronously force IDLE, step_req=0, busy=0, done=0, phase=0, and counters and latched config to 0.
REQ-025 A reset mid-run SHALL abandon the run without a done pulse; start on the first cycle after reset deassertion SHALL be honoured.

Configuration
REQ-026 Macro DFR_SEQ_ABORT_EN SHALL, when defined, add an input abort (1 bit); abort=1 in any active phase forces DONE on the next edge with counters cleared, then IDLE. Abort has priority over a coincident handshake.
REQ-027 Without DFR_SEQ_ABORT_EN, the abort port SHALL be absent and runs complete only via REQ-018 or reset.

Structure
REQ-028 Package dfr_pkg SHALL hold the state enum, the 2-bit phase encoding constants and the default CNT_W.
REQ-029 Sub-module dfr_step_counter SHALL implement the nested step/sample counter with clear, increment and terminal-count outputs.

Verification
REQ-030 init=1, train=2, test=1, steps=3, step_ack tied high: 12 step_req cycles, phase sequence 1x3, 2x6, 3x3, done 1 cycle later.
REQ-031 train=0, init=1, test=1, steps=2: phase goes 1 then 3 with no cycle at phase=2; done after 4 handshakes.
REQ-032 steps=0: start -> busy high 1 cycle in DONE, done pulse, step_req never asserted.
REQ-033 step_ack toggled pseudo-randomly and a start re-pulsed mid-run: indices advance only on handshake, second start ignored, totals match config.
REQ-034 Local_Reset asserted during TRAIN at sample_idx=1: outputs 0 immediately, no done, new start runs a full sequence.
REQ-035 With DFR_SEQ_ABORT_EN, abort during INIT at step 1 -> DONE next cycle, done pulse, counters 0, IDLE after.

Source files
------------

// File: rtl/dfr_pkg.sv
// rtl/dfr_pkg.sv - shared state enum, phase encodings and default counter width
// for the DFR phase sequencer.
package dfr_pkg;

  localparam int unsigned DFR_CNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_TRAIN = 3'd2,
    ST_TEST  = 3'd3,
    ST_DONE  = 3'd4
  } dfr_state_e;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_INIT  = 2'd1;
  localparam logic [1:0] PH_TRAIN = 2'd2;
  localparam logic [1:0] PH_TEST  = 2'd3;

  function automatic logic [1:0] phase_of(input dfr_state_e s);
    case (s)
      ST_INIT:  phase_of = PH_INIT;
      ST_TRAIN: phase_of = PH_TRAIN;
      ST_TEST:  phase_of = PH_TEST;
      default:  phase_of = PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/dfr_step_counter.sv
// rtl/dfr_step_counter.sv - nested step/sample counter with clear, increment and
// terminal-count outputs.
module dfr_step_counter
  import dfr_pkg::*;
#(
  parameter int unsigned CNT_W = DFR_CNT_W
) (
  input  logic             S_AXI_ACLK,
  input  logic             Local_Reset,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] steps_i,
  input  logic [CNT_W-1:0] samples_i,
  output logic [CNT_W-1:0] step_idx_o,
  output logic [CNT_W-1:0] sample_idx_o,
  output logic             step_tc_o,
  output logic             last_o
);

  logic [CNT_W-1:0] step_q, step_d;
  logic [CNT_W-1:0] sample_q, sample_d;

  // Compare against count-1 so a full-scale count never needs an extra bit.
  assign step_tc_o = (step_q == (steps_i - CNT_W'(1)));
  assign last_o    = step_tc_o && (sample_q == (samples_i - CNT_W'(1)));

  always_comb begin
    step_d   = step_q;
    sample_d = sample_q;
    if (clear_i) begin
      step_d   = '0;
      sample_d = '0;
    end else if (inc_i) begin
      if (step_tc_o) begin
        step_d   = '0;
        sample_d = sample_q + CNT_W'(1);
      end else begin
        step_d = step_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      step_q   <= '0;
      sample_q <= '0;
    end else begin
      step_q   <= step_d;
      sample_q <= sample_d;
    end
  end

  assign step_idx_o   = step_q;
  assign sample_idx_o = sample_q;

endmodule

// File: rtl/dfr_phase_sequencer.sv
// rtl/dfr_phase_sequencer.sv - init/train/test phase sequencer issuing one datapath
// step request per reservoir step; optional abort input under DFR_SEQ_ABORT_EN.
module dfr_phase_sequencer
  import dfr_pkg::*;
#(
  parameter int unsigned CNT_W = DFR_CNT_W
) (
  input  logic             S_AXI_ACLK,
  input  logic             Local_Reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_init_samples,
  input  logic [CNT_W-1:0] num_train_samples,
  input  logic [CNT_W-1:0] num_test_samples,
  input  logic [CNT_W-1:0] num_steps_per_sample,
`ifdef DFR_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             step_req,
  input  logic             step_ack,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] sample_idx,
  output logic [CNT_W-1:0] step_idx,
  output logic             busy,
  output logic             done
);

  dfr_state_e       state_q, state_d;
  logic [CNT_W-1:0] init_q, init_d;
  logic [CNT_W-1:0] train_q, train_d;
  logic [CNT_W-1:0] test_q, test_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [CNT_W-1:0] samples_sel;
  logic             active, hs, cnt_clear, cnt_inc, cnt_last, step_tc;
  logic             abort_w;

`ifdef DFR_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign active = (state_q == ST_INIT) || (state_q == ST_TRAIN) || (state_q == ST_TEST);
  assign hs     = active && step_ack;

  always_comb begin
    state_d   = state_q;
    init_d    = init_q;
    train_d   = train_q;
    test_d    = test_q;
    steps_d   = steps_q;
    cnt_clear = 1'b0;
    cnt_inc   = hs && !abort_w;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          init_d  = num_init_samples;
          train_d = num_train_samples;
          test_d  = num_test_samples;
          steps_d = num_steps_per_sample;
          // Entry decision uses the raw inputs because the latch lands on this same edge.
          if (num_steps_per_sample == '0)    state_d = ST_DONE;
          else if (num_init_samples != '0)   state_d = ST_INIT;
          else if (num_train_samples != '0)  state_d = ST_TRAIN;
          else if (num_test_samples != '0)   state_d = ST_TEST;
          else                               state_d = ST_DONE;
        end
      end
      ST_INIT, ST_TRAIN, ST_TEST: begin
        if (abort_w) begin
          state_d   = ST_DONE;
          cnt_clear = 1'b1;
        end else if (hs && cnt_last) begin
          cnt_clear = 1'b1;
          if (state_q == ST_INIT && train_q != '0)       state_d = ST_TRAIN;
          else if (state_q != ST_TEST && test_q != '0)   state_d = ST_TEST;
          else                                           state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      ST_INIT:  samples_sel = init_q;
      ST_TRAIN: samples_sel = train_q;
      ST_TEST:  samples_sel = test_q;
      default:  samples_sel = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      state_q <= ST_IDLE;
      init_q  <= '0;
      train_q <= '0;
      test_q  <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      train_q <= train_d;
      test_q  <= test_d;
      steps_q <= steps_d;
    end
  end

  dfr_step_counter #(.CNT_W(CNT_W)) u_cnt (
    .S_AXI_ACLK   (S_AXI_ACLK),
    .Local_Reset  (Local_Reset),
    .clear_i      (cnt_clear),
    .inc_i        (cnt_inc),
    .steps_i      (steps_q),
    .samples_i    (samples_sel),
    .step_idx_o   (step_idx),
    .sample_idx_o (sample_idx),
    .step_tc_o    (step_tc),
    .last_o       (cnt_last)
  );

  // step_req decodes straight from the state so phase hand-offs leave no bubble.
  assign step_req = active;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign phase    = phase_of(state_q);

endmodule

// File: tb/tb_dfr_phase_sequencer.sv
// tb/tb_dfr_phase_sequencer.sv - scoreboard bench for dfr_phase_sequencer.
module tb_dfr_phase_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         step_ack = 1'b0;
  logic [W-1:0] n_init = '0, n_train = '0, n_test = '0, n_steps = '0;
  logic         step_req, busy, done;
  logic [1:0]   phase;
  logic [W-1:0] sample_idx, step_idx;
  logic         abort_s;
`ifdef DFR_SEQ_ABORT_EN
  logic         abort = 1'b0;
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  dfr_phase_sequencer #(.CNT_W(W)) dut (
    .S_AXI_ACLK           (clk),
    .Local_Reset          (rst),
    .start                (start),
    .num_init_samples     (n_init),
    .num_train_samples    (n_train),
    .num_test_samples     (n_test),
    .num_steps_per_sample (n_steps),
`ifdef DFR_SEQ_ABORT_EN
    .abort                (abort),
`endif
    .step_req             (step_req),
    .step_ack             (step_ack),
    .phase                (phase),
    .sample_idx           (sample_idx),
    .step_idx             (step_idx),
    .busy                 (busy),
    .done                 (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       is_done;
    bit       after_hs;
    logic [1:0] ph;
    int       smp;
    int       stp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_hs_cyc = -10;
  int   ph_cnt[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (step_req) ph_cnt[phase] = ph_cnt[phase] + 1;
      if (step_req && step_ack && !abort_s) begin
        if (q.size() == 0) check("hs_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          check("hs_kind", 64'(e.is_done), 0);
          check("hs_phase_sample_step", {phase, sample_idx, step_idx},
                {e.ph, e.smp[W-1:0], e.stp[W-1:0]});
        end
        last_hs_cyc = cyc;
      end
      if (done) begin
        if (q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          check("done_kind", 64'(e.is_done), 1);
          if (e.after_hs) check("done_latency", cyc, last_hs_cyc + 1);
        end
        check("done_outputs", {busy, step_req, phase, sample_idx, step_idx},
              {1'b1, 1'b0, 2'b00, {W{1'b0}}, {W{1'b0}}});
      end
      if (!busy) check("idle_outputs", {step_req, done, phase, sample_idx, step_idx}, 0);
    end
  end

  task automatic push_run(input int i, input int t, input int s, input int st);
    exp_t x;
    int cnt;
    if (st != 0) begin
      for (int p = 1; p <= 3; p++) begin
        cnt = (p == 1) ? i : (p == 2) ? t : s;
        for (int a = 0; a < cnt; a++)
          for (int b = 0; b < st; b++) begin
            x = '{0, 0, 2'(p), a, b};
            q.push_back(x);
          end
      end
    end
    x = '{1, (st != 0) && ((i + t + s) != 0), 2'd0, 0, 0};
    q.push_back(x);
  endtask

  task automatic clr_cnt();
    for (int k = 0; k < 4; k++) ph_cnt[k] = 0;
  endtask

  task automatic issue_start(input int i, input int t, input int s, input int st);
    push_run(i, t, s, st);
    n_init = W'(i); n_train = W'(t); n_test = W'(s); n_steps = W'(st);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble config mid-run; the latched copy must be the one used.
    n_init = ~W'(i); n_train = ~W'(t); n_test = ~W'(s); n_steps = ~W'(st);
  endtask

  task automatic run(input int i, input int t, input int s, input int st,
                     input bit rnd, input int budget);
    clr_cnt();
    issue_start(i, t, s, st);
    for (int k = 0; k < budget; k++) begin
      if (!busy) break;
      step_ack = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd && k == 5) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("run_in_budget", busy, 0);
    check("queue_drained", q.size(), 0);
    q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit found;
    clr_cnt();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {step_req, busy, done, phase, sample_idx, step_idx}, 0);
    rst = 1'b0;

    // step_ack while idle must not move anything
    step_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    run(1, 2, 1, 3, 0, 100);
    check("t30_init_cycles", ph_cnt[1], 3);
    check("t30_train_cycles", ph_cnt[2], 6);
    check("t30_test_cycles", ph_cnt[3], 3);

    run(1, 0, 1, 2, 0, 100);
    check("t31_init_cycles", ph_cnt[1], 2);
    check("t31_train_cycles", ph_cnt[2], 0);
    check("t31_test_cycles", ph_cnt[3], 2);

    clr_cnt();
    issue_start(1, 1, 1, 0);
    check("t32_done_cycle", {busy, done, step_req}, 3'b110);
    @(posedge clk); #1;
    check("t32_idle_after", {busy, done}, 2'b00);
    issue_start(0, 0, 0, 5);
    check("t32_allzero_done", {busy, done, step_req}, 3'b110);
    @(posedge clk); #1;
    check("t32_no_step_req", ph_cnt[1] + ph_cnt[2] + ph_cnt[3], 0);
    check("t32_queue", q.size(), 0);

    run(2, 1, 2, 2, 1, 400);

    run(15, 0, 0, 15, 0, 400);
    check("full_scale_cycles", ph_cnt[1], 225);

    step_ack = 1'b1;
    clr_cnt();
    issue_start(1, 3, 1, 2);
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (phase == 2'd2 && sample_idx == W'(1)) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("t34_reached_train_s1", found, 1);
    rst = 1'b1;
    #1;
    check("t34_async_reset", {step_req, busy, done, phase, sample_idx, step_idx}, 0);
    q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    run(1, 1, 1, 1, 0, 50);
    check("t34_rerun_cycles", ph_cnt[1] + ph_cnt[2] + ph_cnt[3], 3);

`ifdef DFR_SEQ_ABORT_EN
    step_ack = 1'b1;
    issue_start(2, 1, 1, 3);
    q.delete();
    e = '{0, 0, 2'd1, 0, 0};
    q.push_back(e);
    e = '{1, 0, 2'd0, 0, 0};
    q.push_back(e);
    @(posedge clk); #1;
    check("abort_pre", {phase, step_idx}, {2'd1, W'(1)});
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_done", {done, busy, phase, sample_idx, step_idx},
          {1'b1, 1'b1, 2'd0, {W{1'b0}}, {W{1'b0}}});
    @(posedge clk); #1;
    check("abort_idle", busy, 0);
    check("abort_queue", q.size(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
